// File: rtl/base_aserialize.sv
// Wide-to-narrow serialiser: accepts one ratio*width word (plus sideband) and
// emits it as ratio registered beats on a valid/ready link, o_last on the final beat.
module base_aserialize #(
  parameter int width     = 8,
  parameter int del_width = 0,
  parameter int ratio     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_v,
  input  logic [ratio*width+del_width-1:0] i_d,
  output logic                            i_r,
  output logic                            o_v,
  output logic [width+del_width-1:0]      o_d,
  output logic                            o_last,
  input  logic                            o_r
);

  localparam int RW = ratio * width;
  localparam int DW = RW + del_width;
  localparam int CW = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [CW-1:0] LAST = CW'(ratio - 1);

  logic [RW-1:0]    word_q;
  logic [CW-1:0]    cnt_q;
  logic             full_q;
  logic [width-1:0] pay_q;
  logic             last_q;
  logic             in_xfer;
  logic             out_xfer;

  // Bit 0 of the bus is the most significant bit, so beat 0 sits at the top.
  function automatic logic [width-1:0] beat_of(input logic [RW-1:0] w,
                                               input logic [CW-1:0] k);
    logic [RW-1:0] s;
    s = w << (int'(k) * width);
    return s[RW-1 -: width];
  endfunction

  // The only o_r -> i_r path: a new word may land on the edge the last beat leaves.
  assign i_r      = ~full_q | (o_r & last_q);
  assign in_xfer  = i_v & i_r;
  assign out_xfer = full_q & o_r;
  assign o_v      = full_q;
  assign o_last   = last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      pay_q  <= '0;
      last_q <= 1'b0;
    end else if (in_xfer) begin
      word_q <= i_d[DW-1 -: RW];
      cnt_q  <= '0;
      full_q <= 1'b1;
      pay_q  <= i_d[DW-1 -: width];
      last_q <= (LAST == '0);
    end else if (out_xfer) begin
      if (cnt_q == LAST) begin
        cnt_q  <= '0;
        full_q <= 1'b0;
        last_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
        pay_q  <= beat_of(word_q, cnt_q + CW'(1));
        last_q <= ((cnt_q + CW'(1)) == LAST);
      end
    end
  end

  generate
    if (del_width > 0) begin : g_side
      logic [del_width-1:0] side_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          side_q <= '0;
        end else if (in_xfer) begin
          side_q <= i_d[del_width-1:0];
        end
      end

      assign o_d = {pay_q, side_q};
    end else begin : g_noside
      assign o_d = pay_q;
    end
  endgenerate

endmodule

// File: tb/tb_base_aserialize.sv
// Directed and randomised checks of base_aserialize (ratio=4 with 2-bit sideband,
// plus a ratio=1 instance) against hand-computed beats and a small scoreboard.
module tb_base_aserialize;

  logic        clk;
  logic        rst_n;
  logic        i_v;
  logic [33:0] i_d;
  logic        i_r;
  logic        o_v;
  logic [9:0]  o_d;
  logic        o_last;
  logic        o_r;

  logic        r_iv;
  logic [7:0]  r_id;
  logic        r_ir;
  logic        r_ov;
  logic [7:0]  r_od;
  logic        r_last;
  logic        r_or;

  int checks = 0;
  int errors = 0;

  base_aserialize #(.width(8), .del_width(2), .ratio(4)) dut (
    .clk(clk), .reset(rst_n), .i_v(i_v), .i_d(i_d), .i_r(i_r),
    .o_v(o_v), .o_d(o_d), .o_last(o_last), .o_r(o_r)
  );

  base_aserialize #(.width(8), .del_width(0), .ratio(1)) dut1 (
    .clk(clk), .reset(rst_n), .i_v(r_iv), .i_d(r_id), .i_r(r_ir),
    .o_v(r_ov), .o_d(r_od), .o_last(r_last), .o_r(r_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bt(input logic [31:0] w, input int k);
    return 8'(w >> (8 * (3 - k)));
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_o_v got %b want 0", o_v); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got %b want 0", o_last); end
    checks++; if (o_d !== 10'h0) begin errors++; $display("FAIL reset_o_d got %h want 000", o_d); end
    checks++; if (r_ov !== 1'b0) begin errors++; $display("FAIL reset_r1_o_v got %b want 0", r_ov); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL reset_i_r got %b want 1", i_r); end
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'h11223344;
    @(negedge clk); i_v = 1'b1; i_d = {w, 2'b10}; o_r = 1'b1;
    @(negedge clk); i_v = 1'b0; i_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL single_o_v beat %0d got %b want 1", k, o_v); end
      checks++; if (o_d !== {bt(w, k), 2'b10}) begin errors++; $display("FAIL single_o_d beat %0d got %h want %h", k, o_d, {bt(w, k), 2'b10}); end
      checks++; if (o_last !== (k == 3)) begin errors++; $display("FAIL single_o_last beat %0d got %b want %b", k, o_last, (k == 3)); end
      checks++; if (i_r !== (k == 3)) begin errors++; $display("FAIL single_i_r beat %0d got %b want %b", k, i_r, (k == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", o_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb, w;
    wa = 32'hA0A1A2A3;
    wb = 32'hB0B1B2B3;
    @(negedge clk); i_v = 1'b1; i_d = {wa, 2'b01}; o_r = 1'b1;
    @(negedge clk); i_d = {wb, 2'b11};
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      if (b == 4) i_v = 1'b0;
      #1;
      w = (b < 4) ? wa : wb;
      checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL b2b_gap beat %0d got o_v %b want 1", b, o_v); end
      checks++; if (o_d !== {bt(w, b % 4), (b < 4) ? 2'b01 : 2'b11}) begin errors++; $display("FAIL b2b_o_d beat %0d got %h want %h", b, o_d, {bt(w, b % 4), (b < 4) ? 2'b01 : 2'b11}); end
      if (b == 3) begin
        checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL b2b_accept got i_r %b want 1", i_r); end
      end
    end
    @(negedge clk); #1;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", o_v); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = 32'h11223344;
    @(negedge clk); i_v = 1'b1; i_d = {w, 2'b10}; o_r = 1'b1;
    @(negedge clk); i_v = 1'b0;
    @(negedge clk); o_r = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (o_v !== 1'b1 || o_d !== {8'h22, 2'b10}) begin errors++; $display("FAIL stall_hold cyc %0d got o_v %b o_d %h want 1 %h", c, o_v, o_d, {8'h22, 2'b10}); end
      checks++; if (i_r !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL stall_ctrl cyc %0d got i_r %b o_last %b want 0 0", c, i_r, o_last); end
    end
    o_r = 1'b1;
    for (int k = 2; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (o_v !== 1'b1 || o_d !== {bt(w, k), 2'b10}) begin errors++; $display("FAIL stall_resume beat %0d got %b %h want 1 %h", k, o_v, o_d, {bt(w, k), 2'b10}); end
    end
    @(negedge clk); #1;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", o_v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = 32'hC0C1C2C3;
    @(negedge clk); i_v = 1'b1; i_d = {32'h11223344, 2'b11}; o_r = 1'b1;
    @(negedge clk); i_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_v !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got o_v %b o_last %b want 0 0", o_v, o_last); end
    checks++; if (o_d !== 10'h0) begin errors++; $display("FAIL rstmid_o_d got %h want 000", o_d); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL rstmid_idle cyc %0d got %b want 0", c, o_v); end
    end
    @(negedge clk); i_v = 1'b1; i_d = {w, 2'b01};
    @(negedge clk); i_v = 1'b0; #1;
    checks++; if (o_v !== 1'b1 || o_d !== {8'hC0, 2'b01}) begin errors++; $display("FAIL rstmid_restart got %b %h want 1 %h", o_v, o_d, {8'hC0, 2'b01}); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL rstmid_drain got %b want 0", o_v); end
  endtask

  task automatic test_ratio1();
    logic [7:0] sb[$];
    logic [7:0] seq;
    logic in_x, out_x;
    seq = 8'h00;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c < 250) begin
        r_iv = 1'($urandom_range(0, 1));
        r_or = 1'($urandom_range(0, 1));
      end else if (c < 280) begin
        r_iv = 1'b1;
        r_or = 1'b1;
      end else begin
        r_iv = 1'b0;
        r_or = 1'b1;
      end
      r_id = r_iv ? seq : 8'hEE;
      #1;
      in_x  = r_iv & r_ir;
      out_x = r_ov & r_or;
      checks++; if (r_last !== r_ov) begin errors++; $display("FAIL r1_last cyc %0d got %b want %b", c, r_last, r_ov); end
      if (c > 251 && c < 280) begin
        checks++; if (r_ov !== 1'b1 || r_ir !== 1'b1) begin errors++; $display("FAIL r1_thru cyc %0d got o_v %b i_r %b want 1 1", c, r_ov, r_ir); end
      end
      if (out_x) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL r1_extra cyc %0d got %h want none", c, r_od); end
        else begin
          if (r_od !== sb[0]) begin errors++; $display("FAIL r1_data cyc %0d got %h want %h", c, r_od, sb[0]); end
          void'(sb.pop_front());
        end
      end
      if (in_x) begin
        sb.push_back(r_id);
        seq = seq + 8'd1;
      end
    end
    #1;
    checks++; if (sb.size() != 0 || r_ov !== 1'b0) begin errors++; $display("FAIL r1_loss got %0d pending o_v %b want 0 0", sb.size(), r_ov); end
  endtask

  task automatic test_random();
    logic [33:0] sb[$];
    logic [33:0] w;
    logic [9:0] exp_d;
    logic in_x, out_x;
    int idx;
    idx = 0;
    for (int c = 0; c < 10040; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        i_v = 1'($urandom_range(0, 1));
        o_r = ($urandom_range(0, 3) != 0);
      end else begin
        i_v = 1'b0;
        o_r = 1'b1;
      end
      i_d = {$urandom, 2'($urandom)};
      #1;
      in_x  = i_v & i_r;
      out_x = o_v & o_r;
      if (out_x) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rand_extra cyc %0d got %h want none", c, o_d); end
        else begin
          w = sb[0];
          exp_d = {bt(w[33:2], idx), w[1:0]};
          if (o_d !== exp_d || o_last !== (idx == 3)) begin
            errors++; $display("FAIL rand_beat cyc %0d got %h last %b want %h last %b", c, o_d, o_last, exp_d, (idx == 3));
          end
          idx++;
          if (idx == 4) begin idx = 0; void'(sb.pop_front()); end
        end
      end
      if (in_x) sb.push_back(i_d);
    end
    #1;
    checks++; if (sb.size() != 0 || idx != 0 || o_v !== 1'b0) begin errors++; $display("FAIL rand_drain got %0d pending beat %0d o_v %b want 0 0 0", sb.size(), idx, o_v); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_v = 1'b0; i_d = '0; o_r = 1'b0;
    r_iv = 1'b0; r_id = '0; r_or = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_ratio1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/base_aserialize.md
Name: base_aserialize

Overview:
- Downstream consumer of the aburp/latch stage; serialises one wide valid/ready word into `ratio` narrow beats on a valid/ready output.
- The sideband (del) field travels with every beat. `o_last` marks the final beat of each word.
- Sits between a wide datapath buffer and a narrow egress link.
- Output is fully registered. Input accept is sized for zero-bubble streaming.

Parameters:
- width, 8: payload bits per output beat.
- del_width, 0: sideband bits carried alongside the payload. When 0, the sideband field is absent.
- ratio, 4: output beats per input word (>=1).

Ports:
- clk  input  1  single clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_v  input  1  input word valid.
- i_d  input  ratio*width+del_width  bits [0:ratio*width-1] are payload, beat 0 in the lowest-index bits. The trailing del_width bits are sideband.
- i_r  output  1  input ready.
- o_v  output  1  output beat valid.
- o_d  output  width+del_width  bits [0:width-1] are the beat payload; the trailing del_width bits are sideband.
- o_last  output  1  high on the final beat (beat ratio-1) of a word; qualified by o_v.
- o_r  input  1  output ready.

Behaviour:
- State:
  - word register (ratio*width payload + del_width sideband).
  - full flag.
  - beat counter cnt, width clog2(ratio) (min 1 bit), range 0..ratio-1.
- Reset (reset=0, asynchronous) forces:
  - full=0, cnt=0.
  - o_v=0, o_last=0, o_d=0.
  - word register=0.
  - Release is synchronous to clk. The first accept can occur on the first rising edge with reset=1.
- Transfer rules:
  - An input transfer happens on a rising edge with i_v & i_r.
  - An output transfer happens on a rising edge with o_v & o_r.
- i_r = ~full | (o_r & cnt==ratio-1).
  - This is the only combinational path from o_r to i_r.
  - There is no path from i_v to any output.
- o_v = full.
- o_d:
  - payload = word[cnt*width +: width].
  - sideband = word sideband field, identical on every beat of the word.
- o_last = full & (cnt==ratio-1).
- On an input transfer:
  - word register <= i_d, full <= 1, cnt <= 0.
  - Latency: beat 0 is valid the cycle after acceptance.
- On an output transfer with cnt<ratio-1: cnt <= cnt+1.
- On an output transfer with cnt==ratio-1:
  - If there is no simultaneous input transfer: full <= 0, cnt <= 0.
  - If there is a simultaneous input transfer (back-to-back): load the new word, full stays 1, cnt <= 0. No idle cycle is inserted.
- Throughput: one beat per cycle sustained. One word per ratio cycles when i_v and o_r are held high.
- Stall: while o_v=1 and o_r=0, o_d, o_last and cnt hold stable. o_v never drops without an output transfer.
- i_d is ignored whenever i_r=0. The word register changes only on an input transfer.
- ratio=1:
  - Block acts as a single registered stage; o_last=o_v.
  - i_r = ~full | o_r.
- Reset asserted mid-word: the partially sent word is discarded. After release, output is idle until a new input transfer.
- No error conditions exist. X on i_d while i_v=0 must not propagate to o_d when o_v=1.

Test Plan:
- Single word:
  - Stimulus: width=8, ratio=4, del_width=2; reset released; i_d payload 0x11223344 (beat0=0x11), sideband 2'b10; o_r=1.
  - Required: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting the cycle after accept. Sideband 2'b10 on all four beats. o_last only on 0x44. i_r=0 during beats 0-2 and i_r=1 during beat 3.
- Back-to-back:
  - Stimulus: two words 0xA0A1A2A3 and 0xB0B1B2B3 offered continuously; o_r=1.
  - Required: 8 consecutive valid beats with no gap; the second word is accepted on the edge where 0xA3 transfers.
- Output stall:
  - Stimulus: o_r=0 for 3 cycles at beat 1 of 0x11223344.
  - Required: o_v=1 and o_d=0x22 held constant; cnt does not advance; i_r=0; normal resumption follows.
- Reset mid-word:
  - Stimulus: reset=0 asynchronously after beat 1 transfers.
  - Required: o_v, o_last and o_d go 0 immediately, without waiting for a clock edge. After release, no beats until a new i_v; the next word starts at beat 0.
- ratio=1:
  - Stimulus: width=8, del_width=0; random i_v and o_r.
  - Required: output sequence equals input sequence; o_last==o_v every cycle; full throughput when both are held high.
- Random:
  - Stimulus: random i_v and o_r over 10k cycles.
  - Required: the scoreboard sees beats in order, exactly ratio beats per word, sideband constant within each word, and no loss or duplication.
